// File: rtl/tlc5957_pkg.sv
// tlc5957_pkg: shared word width, command/mode/state types and LAT pulse lengths
package tlc5957_pkg;
  localparam int WORD_WIDTH = 48;
  typedef enum logic [1:0] {WRTGS, LATGS, WRTFC, FCWRTEN} cmd_t;
  typedef enum logic {MODE_GS, MODE_FC} mode_t;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, FINISH} state_t;
  localparam logic [5:0] LAT_WRTGS = 6'd1;
  localparam logic [5:0] LAT_LATGS = 6'd3;
  localparam logic [5:0] LAT_WRTFC = 6'd5;
  localparam logic [5:0] LAT_FCWRTEN = 6'd15;
  function automatic logic [5:0] lat_len(input cmd_t c);
    return c == WRTGS ? LAT_WRTGS : c == LATGS ? LAT_LATGS : c == WRTFC ? LAT_WRTFC : LAT_FCWRTEN;
  endfunction
endpackage

// File: rtl/tlc5957_sclk_gen.sv
// tlc5957_sclk_gen: SCLK_FACTOR-cycle low/high phases while enabled, with strobes on the cycle before each edge
module tlc5957_sclk_gen #(
  parameter int SCLK_FACTOR = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic fall_tick,
  output logic rise_tick
);
  localparam logic [7:0] LAST = 8'(SCLK_FACTOR - 1);
  logic [7:0] phase;
  logic wrap;
  always_comb begin
    wrap = en && phase == LAST;
    rise_tick = wrap && !sclk;
    fall_tick = wrap && sclk;
  end
  // dropping en always parks SCLK low with a fresh low phase
  always_ff @(posedge clk)
    if (rst || !en) begin
      phase <= '0;
      sclk <= 1'b0;
    end else begin
      phase <= wrap ? '0 : phase + 8'd1;
      sclk <= sclk ^ wrap;
    end
endmodule

// File: rtl/tlc5957_tx.sv
// tlc5957_tx: serialises GS rows and FC writes onto a TLC5957 chain (SCLK/SIN/LAT)
module tlc5957_tx
  import tlc5957_pkg::*;
#(
  parameter int SCLK_FACTOR = 4,
  parameter int NB_LEDS_PER_GROUP = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  s_valid,
  input  logic [WORD_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  SCLK,
  output logic                  SIN,
  output logic                  LAT,
  output logic                  busy,
  output logic                  done
);
  localparam int WW = $clog2(NB_LEDS_PER_GROUP) + 1;
  localparam logic [WW-1:0] LAST_GS = WW'(NB_LEDS_PER_GROUP - 1);
  state_t state, state_n;
  cmd_t cmd, cmd_n;
  mode_t md, md_n;
  logic [5:0] bit_cnt, bit_n;
  logic [WW-1:0] word, word_n;
  logic [WORD_WIDTH-1:0] sr, sr_n;
  logic lat_n, fall_tick, rise_tick, last_word;

  tlc5957_sclk_gen #(.SCLK_FACTOR(SCLK_FACTOR)) u_sclk (
    .clk(clk),
    .rst(rst),
    .en(state == SHIFT),
    .sclk(SCLK),
    .fall_tick(fall_tick),
    .rise_tick(rise_tick)
  );

  assign SIN = sr[WORD_WIDTH-1];
  assign s_ready = state == FETCH;
  assign busy = state != IDLE;
  assign done = state == FINISH;

  // bit_cnt counts completed rising edges, so a falling tick with bit_cnt==0 marks the word end
  always_comb begin
    state_n = state;
    cmd_n = cmd;
    md_n = md;
    bit_n = bit_cnt;
    word_n = word;
    sr_n = sr;
    lat_n = state == SHIFT ? LAT : 1'b0;
    last_word = md == MODE_FC ? word == WW'(1) : word == LAST_GS;
    case (state)
      IDLE:
        if (start) begin
          md_n = mode ? MODE_FC : MODE_GS;
          word_n = '0;
          sr_n = '0;
          state_n = mode ? SHIFT : FETCH;
          cmd_n = mode ? FCWRTEN : (NB_LEDS_PER_GROUP == 1 ? LATGS : WRTGS);
        end
      FETCH:
        if (s_valid) begin
          sr_n = s_data;
          state_n = SHIFT;
        end
      SHIFT: begin
        if (rise_tick) bit_n = bit_cnt == 6'd47 ? 6'd0 : bit_cnt + 6'd1;
        if (fall_tick) begin
          sr_n = sr << 1;
          if (bit_cnt == 6'd0) begin
            state_n = last_word ? FINISH : FETCH;
            word_n = last_word ? word : word + WW'(1);
            cmd_n = md == MODE_FC ? WRTFC : (word + WW'(1) == LAST_GS ? LATGS : WRTGS);
          end
          lat_n = state_n == SHIFT && bit_cnt >= 6'd48 - lat_len(cmd);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cmd <= WRTGS;
      md <= MODE_GS;
      bit_cnt <= '0;
      word <= '0;
      sr <= '0;
      LAT <= 1'b0;
    end else begin
      state <= state_n;
      cmd <= cmd_n;
      md <= md_n;
      bit_cnt <= bit_n;
      word <= word_n;
      sr <= sr_n;
      LAT <= lat_n;
    end
endmodule

// File: tb/tb_tlc5957_tx.sv
// tb_tlc5957_tx: directed bench decoding the serial stream with a small TLC5957 receiver model
module tb_tlc5957_tx;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0, s_valid = 1'b0, start1 = 1'b0;
  logic [47:0] s_data = '0;
  logic s_ready, sclk, sin, lat, busy, done;
  logic s_ready1, sclk1, sin1, lat1, busy1, done1;
  int n_checks = 0, n_fail = 0;
  logic [47:0] words [16];
  bit abort = 1'b0, mon_clr = 1'b0;

  always #5 clk = ~clk;

  tlc5957_tx #(.SCLK_FACTOR(4), .NB_LEDS_PER_GROUP(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .SCLK(sclk), .SIN(sin), .LAT(lat), .busy(busy), .done(done)
  );
  tlc5957_tx #(.SCLK_FACTOR(1), .NB_LEDS_PER_GROUP(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(1'b0), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready1), .SCLK(sclk1), .SIN(sin1), .LAT(lat1), .busy(busy1), .done(done1)
  );

  // receiver model for the SCLK_FACTOR=4 instance, sampled on the falling clk edge
  int edges = 0, cyc = 0, rise_cyc = 0, done_cnt = 0, done_edge = 0, done_gap = 0;
  int lat_run = 0, lat_first = 0, stab_bad = 0, stall_bad = 0, run = 0, max_run = 0;
  logic done_sclk = 1'b0, done_lat = 1'b0, p_sclk = 1'b0, p_sin = 1'b0, p_lat = 1'b0;
  logic [47:0] cap = '0, fc_reg = '0;
  logic [47:0] latch1 [16];
  int lat_n_q[$], lat_f_q[$];
  always @(negedge clk) begin
    p_sclk <= sclk;
    p_sin <= sin;
    p_lat <= lat;
    cyc <= cyc + 1;
    if (mon_clr) begin
      edges <= 0;
      done_cnt <= 0;
      lat_run <= 0;
      stab_bad <= 0;
      stall_bad <= 0;
      run <= 0;
      max_run <= 0;
      lat_n_q.delete();
      lat_f_q.delete();
    end else begin
      if (sclk === 1'b1 && p_sclk === 1'b0) begin
        edges <= edges + 1;
        rise_cyc <= cyc;
        cap <= {cap[46:0], sin};
        if (sin !== p_sin || lat !== p_lat) stab_bad <= stab_bad + 1;
        if (lat === 1'b1) begin
          lat_run <= lat_run + 1;
          if (lat_run == 0) lat_first <= edges + 1;
        end
      end
      if (lat === 1'b0 && p_lat === 1'b1) begin
        lat_n_q.push_back(lat_run);
        lat_f_q.push_back(lat_first);
        lat_run <= 0;
        if (lat_run == 1 || lat_run == 3) begin
          for (int i = 15; i > 0; i--) latch1[i] <= latch1[i-1];
          latch1[0] <= cap;
        end
        if (lat_run == 5) fc_reg <= cap;
      end
      if (s_ready === 1'b1) begin
        run <= run + 1;
        if (run + 1 > max_run) max_run <= run + 1;
        if (sclk !== 1'b0 || lat !== 1'b0 || (run > 0 && sin !== p_sin)) stall_bad <= stall_bad + 1;
      end else run <= 0;
      if (done === 1'b1) begin
        done_cnt <= done_cnt + 1;
        done_edge <= edges;
        done_gap <= cyc - rise_cyc;
        done_sclk <= sclk;
        done_lat <= lat;
      end
    end
  end

  // edge-timing monitor for the SCLK_FACTOR=1 instance
  int edges1 = 0, hi_bad1 = 0, stab_bad1 = 0, min_gap1 = 1000, rise_cyc1 = 0;
  logic [47:0] cap1 = '0;
  logic q_sclk1 = 1'b0, q_sin1 = 1'b0, q_lat1 = 1'b0;
  always @(negedge clk) begin
    q_sclk1 <= sclk1;
    q_sin1 <= sin1;
    q_lat1 <= lat1;
    if (mon_clr) begin
      edges1 <= 0;
      hi_bad1 <= 0;
      stab_bad1 <= 0;
      min_gap1 <= 1000;
    end else begin
      if (sclk1 === 1'b1 && q_sclk1 === 1'b0) begin
        edges1 <= edges1 + 1;
        cap1 <= {cap1[46:0], sin1};
        rise_cyc1 <= cyc;
        if (edges1 > 0 && cyc - rise_cyc1 < min_gap1) min_gap1 <= cyc - rise_cyc1;
        if (sin1 !== q_sin1 || lat1 !== q_lat1) stab_bad1 <= stab_bad1 + 1;
      end
      if (sclk1 === 1'b1 && q_sclk1 === 1'b1) hi_bad1 <= hi_bad1 + 1;
    end
  end

  task automatic clr();
    mon_clr = 1'b1;
    repeat (2) @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic fill_words();
    for (int i = 0; i < 16; i++) words[i] = {16'($urandom), 32'($urandom)};
  endtask

  task automatic pulse_start(input logic m, input bit fast);
    if (fast) start1 = 1'b1; else begin start = 1'b1; mode = m; end
    @(negedge clk);
    start = 1'b0;
    start1 = 1'b0;
    mode = 1'b0;
  endtask

  // feeds n words; optionally holds s_valid low for 100 FETCH cycles before word stall_idx
  task automatic feed(input int n, input int stall_idx, input bit fast);
    for (int i = 0; i < n && !abort; i++) begin
      int guard;
      guard = 0;
      if (i == stall_idx) begin
        while (s_ready !== 1'b1 && guard < 2000) begin @(negedge clk); guard++; end
        repeat (100) @(negedge clk);
      end
      s_valid = 1'b1;
      s_data = words[i];
      guard = 0;
      while ((fast ? s_ready1 : s_ready) !== 1'b1 && !abort && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({sclk, sin, lat, s_ready, busy, done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000", {sclk, sin, lat, s_ready, busy, done});
    end
    rst = 1'b0;
    clr();
  endtask

  task automatic test_fc_write();
    clr();
    words[0] = 48'h5c0201008048;
    pulse_start(1'b1, 1'b0);
    feed(1, -1, 1'b0);
    wait_done();
    n_checks++;
    if (edges != 96) begin n_fail++; $display("FAIL fc_edges: got %0d expected 96", edges); end
    n_checks++;
    if (lat_n_q.size() != 2) begin n_fail++; $display("FAIL fc_lat_runs: got %0d expected 2", lat_n_q.size()); end
    n_checks++;
    if (lat_f_q[0] != 34 || lat_n_q[0] != 15) begin
      n_fail++;
      $display("FAIL fc_lat_fcwrten: got first %0d len %0d expected first 34 len 15", lat_f_q[0], lat_n_q[0]);
    end
    n_checks++;
    if (lat_f_q[1] != 92 || lat_n_q[1] != 5) begin
      n_fail++;
      $display("FAIL fc_lat_wrtfc: got first %0d len %0d expected first 92 len 5", lat_f_q[1], lat_n_q[1]);
    end
    n_checks++;
    if (cap !== 48'h5c0201008048) begin n_fail++; $display("FAIL fc_data: got %h expected 5c0201008048", cap); end
    n_checks++;
    if (fc_reg !== 48'h5c0201008048) begin n_fail++; $display("FAIL fc_reg: got %h expected 5c0201008048", fc_reg); end
    n_checks++;
    if (done_cnt != 1 || done_edge != 96) begin
      n_fail++;
      $display("FAIL fc_done: got %0d dones at edge %0d expected 1 at edge 96", done_cnt, done_edge);
    end
    n_checks++;
    if (done_gap != 4) begin n_fail++; $display("FAIL fc_done_gap: got %0d cycles expected 4", done_gap); end
    n_checks++;
    if ({done_sclk, done_lat} !== 2'b00) begin
      n_fail++;
      $display("FAIL fc_done_lines: got sclk/lat %b expected 00", {done_sclk, done_lat});
    end
  endtask

  task automatic test_gs_row();
    int bad;
    fill_words();
    clr();
    pulse_start(1'b0, 1'b0);
    feed(16, -1, 1'b0);
    wait_done();
    n_checks++;
    if (edges != 768) begin n_fail++; $display("FAIL gs_edges: got %0d expected 768", edges); end
    bad = 0;
    for (int i = 0; i < 16; i++) if (lat_n_q[i] != (i == 15 ? 3 : 1)) bad++;
    n_checks++;
    if (bad != 0 || lat_n_q.size() != 16) begin
      n_fail++;
      $display("FAIL gs_lat_counts: got %0d runs, %0d wrong, last %0d expected 16 runs 1x15 then 3", lat_n_q.size(), bad, lat_n_q[15]);
    end
    for (int l = 0; l < 16; l++) begin
      n_checks++;
      if (latch1[l] !== words[15-l]) begin
        n_fail++;
        $display("FAIL gs_latch_led%0d: got %h expected %h", l, latch1[l], words[15-l]);
      end
    end
    n_checks++;
    if (stab_bad != 0) begin n_fail++; $display("FAIL gs_sin_lat_stable: got %0d changes at rising edges expected 0", stab_bad); end
    n_checks++;
    if (done_cnt != 1 || done_gap != 4) begin
      n_fail++;
      $display("FAIL gs_done: got %0d dones gap %0d expected 1 gap 4", done_cnt, done_gap);
    end
  endtask

  task automatic test_stall();
    int bad;
    fill_words();
    clr();
    pulse_start(1'b0, 1'b0);
    feed(16, 5, 1'b0);
    wait_done();
    n_checks++;
    if (max_run < 100) begin n_fail++; $display("FAIL stall_length: got %0d fetch cycles expected >= 100", max_run); end
    n_checks++;
    if (stall_bad != 0) begin n_fail++; $display("FAIL stall_lines: got %0d bad cycles expected 0", stall_bad); end
    bad = 0;
    for (int l = 0; l < 16; l++) if (latch1[l] !== words[15-l]) bad++;
    n_checks++;
    if (bad != 0 || edges != 768) begin
      n_fail++;
      $display("FAIL stall_data: got %0d wrong leds %0d edges expected 0 wrong 768 edges", bad, edges);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    fill_words();
    clr();
    pulse_start(1'b0, 1'b0);
    fork
      feed(16, -1, 1'b0);
      begin
        for (int k = 0; k < 5000 && edges < 164; k++) @(negedge clk);
        rst = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({sclk, sin, lat, s_ready, busy, done} !== 6'b0) begin
          n_fail++;
          $display("FAIL midreset_outputs: got %b expected 000000", {sclk, sin, lat, s_ready, busy, done});
        end
        rst = 1'b0;
      end
    join
    abort = 1'b0;
    s_valid = 1'b0;
    fill_words();
    clr();
    pulse_start(1'b0, 1'b0);
    feed(16, -1, 1'b0);
    wait_done();
    bad = 0;
    for (int l = 0; l < 16; l++) if (latch1[l] !== words[15-l]) bad++;
    n_checks++;
    if (bad != 0 || edges != 768 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL midreset_rerun: got %0d wrong leds %0d edges %0d dones expected 0 768 1", bad, edges, done_cnt);
    end
  endtask

  task automatic test_start_ignored();
    int bad;
    fill_words();
    clr();
    pulse_start(1'b0, 1'b0);
    fork
      feed(16, -1, 1'b0);
      begin
        for (int k = 0; k < 5000 && edges < 10; k++) @(negedge clk);
        pulse_start(1'b1, 1'b0);
      end
    join
    wait_done();
    repeat (600) @(negedge clk);
    bad = 0;
    for (int l = 0; l < 16; l++) if (latch1[l] !== words[15-l]) bad++;
    n_checks++;
    if (edges != 768) begin n_fail++; $display("FAIL ignore_edges: got %0d expected 768", edges); end
    n_checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_done: got %0d dones busy %b expected 1 dones busy 0", done_cnt, busy);
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL ignore_data: got %0d wrong leds expected 0", bad); end
  endtask

  task automatic test_fast_sclk();
    fill_words();
    clr();
    pulse_start(1'b0, 1'b1);
    feed(16, -1, 1'b1);
    for (int k = 0; k < 3000 && done1 !== 1'b1; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_checks++;
    if (edges1 != 768) begin n_fail++; $display("FAIL fast_edges: got %0d expected 768", edges1); end
    n_checks++;
    if (min_gap1 != 2 || hi_bad1 != 0) begin
      n_fail++;
      $display("FAIL fast_period: got min period %0d long highs %0d expected 2 and 0", min_gap1, hi_bad1);
    end
    n_checks++;
    if (stab_bad1 != 0) begin n_fail++; $display("FAIL fast_stable: got %0d changes at rising edges expected 0", stab_bad1); end
    n_checks++;
    if (cap1 !== words[15]) begin n_fail++; $display("FAIL fast_data: got %h expected %h", cap1, words[15]); end
  endtask

  initial begin
    test_reset();
    test_fc_write();
    test_gs_row();
    test_stall();
    test_reset_mid();
    test_start_ignored();
    test_fast_sclk();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tlc5957_tx.md
TLC5957_TX -- requirements
Module: tlc5957_tx

Interface
REQ-001 SHALL have parameter SCLK_FACTOR, default 4: clk cycles per SCLK phase (low or high), legal range 1..255.
REQ-002 SHALL have parameter NB_LEDS_PER_GROUP, default 16: 48-bit words per grayscale row.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a transfer.
REQ-006 SHALL have port mode  input  1  transfer type, sampled with start: 0 = GS row, 1 = FC write.
REQ-007 SHALL have port s_valid  input  1  data word available.
REQ-008 SHALL have port s_data  input  48  data word, MSB first on the wire.
REQ-009 SHALL have port s_ready  output  1  word accepted on any cycle where s_valid and s_ready are both high.
REQ-010 SHALL have port SCLK  output  1  serial clock to the TLC5957 chain.
REQ-011 SHALL have port SIN  output  1  serial data to the TLC5957 chain.
REQ-012 SHALL have port LAT  output  1  latch/command strobe.
REQ-013 SHALL have port busy  output  1  transfer in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a transfer completes.

Function
REQ-015 SHALL implement states IDLE, FETCH, SHIFT and FINISH.
- IDLE: busy=0; start -> FETCH, or -> SHIFT for the FC preamble word; mode latched.
- FETCH: s_ready=1; on handshake load s_data into a 48-bit shift register -> SHIFT.
- SHIFT: 48 SCLK periods per word.
- FINISH: done=1 for one cycle -> IDLE.
REQ-016 SHALL ignore start while busy=1.
REQ-017 SHALL drive each SCLK period as SCLK_FACTOR cycles low followed by SCLK_FACTOR cycles high.
REQ-018 SHALL update SIN and LAT only on the cycle where SCLK goes low, or on the first SHIFT cycle, so both are stable for at least SCLK_FACTOR cycles before each rising edge.
REQ-019 SHALL drive SIN as shift-register bit 47 and shift left by one after each SCLK rising edge.
REQ-020 SHALL hold LAT high for exactly the last N rising edges of a word (bit indices 48-N..47), where N is set by the command:
- WRTGS: N=1.
- LATGS: N=3.
- WRTFC: N=5.
- FCWRTEN: N=15.
REQ-021 SHALL send a GS row as NB_LEDS_PER_GROUP fetched words: words 0..NB_LEDS_PER_GROUP-2 with WRTGS and the last word with LATGS.
REQ-022 SHALL send an FC write as one all-zero FCWRTEN word (no fetch) followed by one fetched word with WRTFC.
REQ-023 SHALL keep SCLK low and LAT low, hold SIN and stall indefinitely while FETCH waits for s_valid; there is no timeout.
REQ-024 SHALL go from the end of one word to FETCH for the next word with SCLK low, so there is no SCLK pulse between words.
REQ-025 SHALL take exactly SCLK_FACTOR cycles from a FETCH handshake to the first SCLK rising edge.
REQ-026 SHALL take SCLK_FACTOR cycles from the last rising edge of the final word until done, with SCLK and LAT low at done.
REQ-027 SHALL size the bit counter at 6 bits, counting 0..47 and wrapping to 0 at each word boundary.
REQ-028 SHALL size the word counter at $clog2(NB_LEDS_PER_GROUP)+1 bits, with no wrap within a transfer.
REQ-029 SHALL size the phase counter at 8 bits.

Reset
REQ-030 SHALL, when rst=1 on a rising clk edge, including mid-transfer, on the next cycle go to IDLE and drive SCLK=0, SIN=0, LAT=0, s_ready=0, busy=0, done=0, and clear all counters and the shift register.
REQ-031 SHALL give rst priority over start when both are high in the same cycle, with start discarded.

Structure
REQ-032 SHALL take the following from a shared package tlc5957_pkg:
- WORD_WIDTH=48.
- The command typedef (WRTGS, LATGS, WRTFC, FCWRTEN).
- The LAT-count constants 1, 3, 5 and 15.
- The mode typedef.
REQ-033 SHALL place SCLK phase generation in one sub-module, tlc5957_sclk_gen, which takes an enable, outputs SCLK, and outputs one-cycle fall_tick and rise_tick strobes.

Verification
REQ-034 SHALL cover FC write with s_data=48'h5c0201008048 and SCLK_FACTOR=4 -> 96 SCLK rising edges, LAT high for edges 34..48 and 92..96, the bits captured on edges 49..96 equal 48'h5c0201008048 MSB first, and done 4 cycles after edge 96.
REQ-035 SHALL cover a GS row of 16 random words into the tlc5957 model -> GS_data_latch[1][led] equals word 15-led for every led, LAT counts 1 x15 then 3, and 768 edges in total.
REQ-036 SHALL cover s_valid held low for 100 cycles before word 5 -> SCLK and LAT low and SIN constant for the whole gap, and captured data unchanged.
REQ-037 SHALL cover rst asserted at edge 20 of word 3 -> all outputs 0 the next cycle, and a new GS transfer then completes correctly.
REQ-038 SHALL cover start pulsed at edge 10 with mode=1 during a GS row -> pulse ignored, exactly 768 edges, and a single done.
REQ-039 SHALL cover SCLK_FACTOR=1 -> SCLK period of 2 cycles, and SIN and LAT never change in the same cycle as a SCLK rising edge.
